// File: rtl/conv2d_pad_scheduler.sv
// Walks a zero-padded (HEIGHT+2)x(WIDTH+2) frame row-major, popping all channel FIFOs together on interior
// positions. One pixel per cycle, registered output; holds pix_out and stops issuing while pix_valid && !pix_ready.
module conv2d_pad_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 8,
    parameter int WIDTH      = 112,
    parameter int HEIGHT     = 112
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [CHANNELS-1:0]            fifo_empty,
    input  logic [CHANNELS*DATA_WIDTH-1:0] fifo_data,
    output logic                           fifo_rdreq,
    output logic [CHANNELS*DATA_WIDTH-1:0] pix_out,
    output logic                           pix_valid,
    input  logic                           pix_ready,
    output logic                           busy,
    output logic                           done
);

    localparam int MAX_DIM = (WIDTH > HEIGHT) ? WIDTH : HEIGHT;
    localparam int CW      = $clog2(MAX_DIM + 2);

    localparam logic [CW-1:0] COL_W    = CW'(WIDTH);
    localparam logic [CW-1:0] ROW_H    = CW'(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH + 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(HEIGHT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                         state_q;
    logic [CW-1:0]                  row_q;
    logic [CW-1:0]                  col_q;
    logic [CHANNELS*DATA_WIDTH-1:0] pix_q;
    logic                           pix_vld_q;
    logic                           busy_q;
    logic                           done_q;

    logic interior;
    logic can_emit;
    logic fire;
    logic last_pos;

    assign interior = (row_q != '0) && (row_q <= ROW_H) && (col_q != '0) && (col_q <= COL_W);
    assign can_emit = !pix_vld_q || pix_ready;
    // Interior positions wait for every channel so the channels never skew.
    assign fire     = (state_q == S_RUN) && can_emit && (!interior || (fifo_empty == '0));
    assign last_pos = (row_q == ROW_LAST) && (col_q == COL_LAST);

    assign fifo_rdreq = fire && interior;
    assign pix_out    = pix_q;
    assign pix_valid  = pix_vld_q;
    assign busy       = busy_q;
    assign done       = done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            pix_q     <= '0;
            pix_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        row_q   <= '0;
                        col_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (fire) begin
                        if (last_pos) begin
                            state_q <= S_DRAIN;
                            row_q   <= '0;
                            col_q   <= '0;
                        end else if (col_q == COL_LAST) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!pix_vld_q || pix_ready) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (fire) begin
                pix_q     <= interior ? fifo_data : '0;
                pix_vld_q <= 1'b1;
            end else if (pix_ready) begin
                pix_vld_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv2d_pad_scheduler.sv
// Directed bench: a 4x3 instance for the scenario tasks and a default 112x112 instance for a randomised full frame.
module tb_conv2d_pad_scheduler;

    localparam int DW = 32;
    localparam int CH = 8;
    localparam int SW = 4;
    localparam int SH = 3;
    localparam int BW = 112;
    localparam int BH = 112;
    localparam int SBEATS = (SW + 2) * (SH + 2);
    localparam int SPOPS  = SW * SH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Small instance
    logic             s_rst, s_start, s_rdreq, s_valid, s_ready, s_busy, s_done;
    logic [CH-1:0]    s_empty;
    logic [CH*DW-1:0] s_data, s_pix;
    int               s_pops = 0;

    conv2d_pad_scheduler #(.DATA_WIDTH(DW), .CHANNELS(CH), .WIDTH(SW), .HEIGHT(SH)) u_small (
        .clk(clk), .rst(s_rst), .start(s_start), .fifo_empty(s_empty), .fifo_data(s_data),
        .fifo_rdreq(s_rdreq), .pix_out(s_pix), .pix_valid(s_valid), .pix_ready(s_ready),
        .busy(s_busy), .done(s_done)
    );

    // Default-parameter instance
    logic             b_rst, b_start, b_rdreq, b_valid, b_ready, b_busy, b_done;
    logic [CH-1:0]    b_empty;
    logic [CH*DW-1:0] b_data, b_pix;
    int               b_pops = 0;

    conv2d_pad_scheduler u_big (
        .clk(clk), .rst(b_rst), .start(b_start), .fifo_empty(b_empty), .fifo_data(b_data),
        .fifo_rdreq(b_rdreq), .pix_out(b_pix), .pix_valid(b_valid), .pix_ready(b_ready),
        .busy(b_busy), .done(b_done)
    );

    // Show-ahead FIFO models: channel i head is {i+1, pop index}, never zero.
    always @(posedge clk) if (s_rdreq) s_pops <= s_pops + 1;
    always @(posedge clk) if (b_rdreq) b_pops <= b_pops + 1;
    always_comb begin
        s_data = '0;
        b_data = '0;
        for (int i = 0; i < CH; i++) begin
            s_data[i*DW +: DW] = {8'(i + 1), 24'(s_pops)};
            b_data[i*DW +: DW] = {8'(i + 1), 24'(b_pops)};
        end
    end

    // Beat recorder for the small instance
    logic [CH*DW-1:0] s_beats[$];
    int               s_beat_cyc[$];
    int               s_nrd = 0;
    int               s_ndone = 0;
    int               s_done_cyc = 0;
    always @(negedge clk) begin
        if (s_valid && s_ready) begin
            s_beats.push_back(s_pix);
            s_beat_cyc.push_back(cyc);
        end
        if (s_rdreq) s_nrd <= s_nrd + 1;
        if (s_done) begin
            s_ndone    <= s_ndone + 1;
            s_done_cyc <= cyc;
        end
    end

    function automatic logic [CH*DW-1:0] exp_pix(input int p, input int w, input int h, input int base);
        int r, c, k;
        logic [CH*DW-1:0] v;
        v = '0;
        r = p / (w + 2);
        c = p % (w + 2);
        if (r >= 1 && r <= h && c >= 1 && c <= w) begin
            k = base + (r - 1) * w + (c - 1);
            for (int i = 0; i < CH; i++) v[i*DW +: DW] = {8'(i + 1), 24'(k)};
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse(output int scyc);
        s_start = 1'b1;
        scyc    = cyc;
        tick();
        s_start = 1'b0;
    endtask

    task automatic wait_frame(input int max_cyc, output bit ok);
        int n0;
        n0 = s_ndone;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (s_ndone > n0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_beats(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (s_beats.size() >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        s_rst = 1'b1; b_rst = 1'b1;
        s_start = 1'b0; b_start = 1'b0;
        s_empty = '0; b_empty = '0;
        s_ready = 1'b1; b_ready = 1'b1;
        #2;
        s_rst = 1'b0; b_rst = 1'b0;
        #1;
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", s_valid); end
        checks++; if (s_pix !== '0) begin errors++; $display("FAIL reset_pix: got %0h want 0", s_pix); end
        checks++; if (s_busy !== 1'b0 || s_done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", s_busy, s_done); end
        checks++; if (b_valid !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL reset_big: got valid=%b busy=%b want 0 0", b_valid, b_busy); end
        repeat (3) tick();
        checks++; if (s_rdreq !== 1'b0) begin errors++; $display("FAIL reset_rdreq: got %b want 0", s_rdreq); end
        s_rst = 1'b1; b_rst = 1'b1;
        repeat (3) tick();
        checks++; if (s_busy !== 1'b0 || s_nrd !== 0) begin errors++; $display("FAIL idle_after_reset: got busy=%b pops=%0d want 0 0", s_busy, s_nrd); end
    endtask

    task automatic test_unstalled();
        int b0, base, rd0, d0, sc, lastc;
        bit ok;
        b0 = s_beats.size(); base = s_pops; rd0 = s_nrd; d0 = s_ndone;
        start_pulse(sc);
        wait_frame(200, ok);
        repeat (3) tick();
        checks++; if (!ok) begin errors++; $display("FAIL unstalled_done: got timeout want done"); end
        checks++; if (s_beats.size() - b0 != SBEATS) begin errors++; $display("FAIL unstalled_beats: got %0d want %0d", s_beats.size() - b0, SBEATS); end
        checks++; if (s_nrd - rd0 != SPOPS) begin errors++; $display("FAIL unstalled_pops: got %0d want %0d", s_nrd - rd0, SPOPS); end
        checks++; if (s_ndone - d0 != 1) begin errors++; $display("FAIL unstalled_done_count: got %0d want 1", s_ndone - d0); end
        checks++; if (s_beat_cyc[b0] != sc + 2) begin errors++; $display("FAIL start_latency: got cycle %0d want %0d", s_beat_cyc[b0], sc + 2); end
        lastc = s_beat_cyc[b0 + SBEATS - 1];
        checks++; if (lastc != s_beat_cyc[b0] + SBEATS - 1) begin errors++; $display("FAIL throughput: got last beat cycle %0d want %0d", lastc, s_beat_cyc[b0] + SBEATS - 1); end
        checks++; if (s_done_cyc != lastc + 1) begin errors++; $display("FAIL done_timing: got cycle %0d want %0d", s_done_cyc, lastc + 1); end
        checks++; if (s_beats[b0 + 7][DW-1:0] !== {8'd1, 24'(base)}) begin errors++; $display("FAIL pixel7_ch0: got %0h want %0h", s_beats[b0 + 7][DW-1:0], {8'd1, 24'(base)}); end
        for (int p = 0; p < SBEATS; p++) begin
            checks++;
            if (s_beats[b0 + p] !== exp_pix(p, SW, SH, base)) begin
                errors++; $display("FAIL unstalled_pix%0d: got %0h want %0h", p, s_beats[b0 + p], exp_pix(p, SW, SH, base));
            end
        end
    endtask

    task automatic test_single_empty_channel();
        int b0, base, rd0, sc, pp;
        bit ok;
        b0 = s_beats.size(); base = s_pops; rd0 = s_nrd;
        start_pulse(sc);
        wait_beats(b0 + 14, ok);
        checks++; if (!ok) begin errors++; $display("FAIL empty_reach: got timeout want beat 14"); end
        s_empty[5] = 1'b1;
        pp = s_pops;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (s_rdreq !== 1'b0) begin errors++; $display("FAIL empty_rdreq%0d: got %b want 0", i, s_rdreq); end
            tick();
        end
        checks++; if (s_beats.size() - b0 != 15) begin errors++; $display("FAIL empty_no_beat: got %0d want 15", s_beats.size() - b0); end
        checks++; if (s_pops != pp) begin errors++; $display("FAIL empty_heads: got %0d want %0d", s_pops, pp); end
        s_empty[5] = 1'b0;
        wait_frame(200, ok);
        checks++; if (!ok || s_beats.size() - b0 != SBEATS || s_nrd - rd0 != SPOPS) begin
            errors++; $display("FAIL empty_totals: got done=%b beats=%0d pops=%0d want 1 %0d %0d", ok, s_beats.size() - b0, s_nrd - rd0, SBEATS, SPOPS);
        end
        for (int p = 0; p < SBEATS; p++) begin
            checks++;
            if (s_beats[b0 + p] !== exp_pix(p, SW, SH, base)) begin
                errors++; $display("FAIL empty_pix%0d: got %0h want %0h", p, s_beats[b0 + p], exp_pix(p, SW, SH, base));
            end
        end
    endtask

    task automatic test_backpressure();
        int b0, base, rd0, sc;
        bit ok;
        b0 = s_beats.size(); base = s_pops; rd0 = s_nrd;
        start_pulse(sc);
        wait_beats(b0 + 8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_reach: got timeout want beat 8"); end
        s_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (s_valid !== 1'b1 || s_pix !== exp_pix(8, SW, SH, base) || s_rdreq !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d: got valid=%b rdreq=%b pix=%0h want 1 0 %0h", i, s_valid, s_rdreq, s_pix, exp_pix(8, SW, SH, base));
            end
            tick();
        end
        s_ready = 1'b1;
        wait_frame(200, ok);
        checks++; if (!ok || s_beats.size() - b0 != SBEATS || s_nrd - rd0 != SPOPS) begin
            errors++; $display("FAIL bp_totals: got done=%b beats=%0d pops=%0d want 1 %0d %0d", ok, s_beats.size() - b0, s_nrd - rd0, SBEATS, SPOPS);
        end
        for (int p = 0; p < SBEATS; p++) begin
            checks++;
            if (s_beats[b0 + p] !== exp_pix(p, SW, SH, base)) begin
                errors++; $display("FAIL bp_pix%0d: got %0h want %0h", p, s_beats[b0 + p], exp_pix(p, SW, SH, base));
            end
        end
    endtask

    task automatic test_start_handling();
        int b0, base, d0, sc;
        bit ok, found;
        b0 = s_beats.size(); d0 = s_ndone;
        start_pulse(sc);
        wait_beats(b0 + 5, ok);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        wait_frame(200, ok);
        repeat (4) tick();
        checks++; if (!ok || s_beats.size() - b0 != SBEATS || s_ndone - d0 != 1 || s_busy !== 1'b0) begin
            errors++; $display("FAIL start_in_run: got beats=%0d dones=%0d busy=%b want %0d 1 0", s_beats.size() - b0, s_ndone - d0, s_busy, SBEATS);
        end
        b0 = s_beats.size(); base = s_pops;
        s_start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_done) begin found = 1'b1; break; end
        end
        checks++; if (!found || s_busy !== 1'b0) begin errors++; $display("FAIL held_done: got found=%b busy=%b want 1 0", found, s_busy); end
        checks++; if (s_beats.size() - b0 != SBEATS) begin errors++; $display("FAIL held_frame1: got %0d want %0d", s_beats.size() - b0, SBEATS); end
        @(negedge clk);
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL held_idle_busy: got %b want 0", s_busy); end
        @(negedge clk);
        checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL held_restart_busy: got %b want 1", s_busy); end
        tick();
        s_start = 1'b0;
        wait_frame(200, ok);
        checks++; if (!ok || s_beats.size() - b0 != 2 * SBEATS) begin errors++; $display("FAIL held_frame2: got done=%b beats=%0d want 1 %0d", ok, s_beats.size() - b0, 2 * SBEATS); end
        for (int p = 0; p < SBEATS; p++) begin
            checks++;
            if (s_beats[b0 + SBEATS + p] !== exp_pix(p, SW, SH, base + SPOPS)) begin
                errors++; $display("FAIL held_pix%0d: got %0h want %0h", p, s_beats[b0 + SBEATS + p], exp_pix(p, SW, SH, base + SPOPS));
            end
        end
    endtask

    task automatic test_reset_midframe();
        int b0, base, rd0, sc;
        bit ok;
        b0 = s_beats.size();
        start_pulse(sc);
        wait_beats(b0 + 10, ok);
        s_rst = 1'b0;
        #1;
        checks++; if (s_valid !== 1'b0 || s_pix !== '0 || s_busy !== 1'b0 || s_done !== 1'b0 || s_rdreq !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: got valid=%b busy=%b done=%b rdreq=%b pix=%0h want all 0", s_valid, s_busy, s_done, s_rdreq, s_pix);
        end
        repeat (2) tick();
        s_rst = 1'b1;
        rd0 = s_nrd;
        repeat (5) tick();
        checks++; if (s_nrd != rd0 || s_busy !== 1'b0) begin errors++; $display("FAIL midreset_idle: got pops=%0d busy=%b want 0 0", s_nrd - rd0, s_busy); end
        b0 = s_beats.size(); base = s_pops;
        start_pulse(sc);
        wait_frame(200, ok);
        checks++; if (!ok || s_beats.size() - b0 != SBEATS || s_nrd - rd0 != SPOPS) begin
            errors++; $display("FAIL midreset_frame: got done=%b beats=%0d pops=%0d want 1 %0d %0d", ok, s_beats.size() - b0, s_nrd - rd0, SBEATS, SPOPS);
        end
        for (int p = 0; p < SBEATS; p++) begin
            checks++;
            if (s_beats[b0 + p] !== exp_pix(p, SW, SH, base)) begin
                errors++; $display("FAIL midreset_pix%0d: got %0h want %0h", p, s_beats[b0 + p], exp_pix(p, SW, SH, base));
            end
        end
    endtask

    task automatic test_default_frame();
        int nb, nr, bad, first_bad, base;
        bit seen_done;
        nb = 0; nr = 0; bad = 0; first_bad = -1; seen_done = 1'b0;
        base = b_pops;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 60000; i++) begin
            b_ready = ($urandom_range(0, 3) != 0);
            b_empty = ($urandom_range(0, 4) == 0) ? CH'($urandom_range(1, 255)) : '0;
            @(negedge clk);
            if (b_valid && b_ready) begin
                if (b_pix !== exp_pix(nb, BW, BH, base)) begin
                    bad++;
                    if (first_bad < 0) first_bad = nb;
                end
                nb++;
            end
            if (b_rdreq) nr++;
            if (b_done) begin seen_done = 1'b1; break; end
            tick();
        end
        tick();
        b_ready = 1'b1;
        b_empty = '0;
        checks++; if (!seen_done) begin errors++; $display("FAIL default_done: got timeout want done"); end
        checks++; if (nb != (BW + 2) * (BH + 2)) begin errors++; $display("FAIL default_beats: got %0d want %0d", nb, (BW + 2) * (BH + 2)); end
        checks++; if (nr != BW * BH) begin errors++; $display("FAIL default_pops: got %0d want %0d", nr, BW * BH); end
        checks++; if (bad != 0) begin errors++; $display("FAIL default_pattern: got %0d bad beats (first %0d) want 0", bad, first_bad); end
    endtask

    initial begin
        test_reset();
        test_unstalled();
        test_single_empty_channel();
        test_backpressure();
        test_start_handling();
        test_reset_midframe();
        test_default_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
